// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bitrev_reorder
//  Description : Ping-pong reorder buffer for a 64-point FFT. It accepts each
//                frame in bit-reversed index order and re-emits it in natural
//                index order. Frames may arrive back to back, and gaps are
//                allowed inside a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int LOG2N = 6,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int               c_N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] c_ONE  = LOG2N'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_READ = 1'b1;

    // Writer state
    logic [LOG2N-1:0] r_wcnt;
    logic             r_wbank;
    logic [LOG2N-1:0] w_waddr;
    logic             w_wr_done;

    // Reader state
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [LOG2N-1:0] r_rcnt;
    logic [LOG2N-1:0] w_rcnt_nxt;
    logic             r_rbank;
    logic             w_rbank_nxt;
    logic             w_issue;
    logic [LOG2N-1:0] w_raddr;
    logic             w_rd_done;

    // Bank bookkeeping
    logic [1:0]       r_full;
    logic [1:0]       w_set_mask;
    logic [1:0]       w_clr_mask;

    // Storage: the bank select is the top address bit
    logic [2*WIDTH-1:0] r_mem [0:2*c_N-1];
    logic [2*WIDTH-1:0] r_rd_data;
    logic               r_do_en;

    // Write address is the bit-reversed sample counter
    for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
        assign w_waddr[i] = r_wcnt[LOG2N-1-i];
    end

    assign w_wr_done = di_en && (r_wcnt == c_LAST);

    // Writer: count valid samples and toggle the write bank at frame end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (di_en) begin
            r_wcnt <= r_wcnt + c_ONE;
            if (r_wcnt == c_LAST) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Full-flag set/clear masks for the completing write and finishing read
    always_comb begin
        w_set_mask = 2'b00;
        w_clr_mask = 2'b00;
        if (w_wr_done) begin
            w_set_mask = r_wbank ? 2'b10 : 2'b01;
        end
        if (w_rd_done) begin
            w_clr_mask = r_rbank ? 2'b10 : 2'b01;
        end
    end

    // Full flags: a bank is full from its last write until its last read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_clr_mask) | w_set_mask;
        end
    end

    // RAM: write port from the writer, registered read port from the reader.
    // A same-address write and read returns the old data, which is what a
    // draining bank needs while its refill has already started.
    always_ff @(posedge clock) begin
        if (di_en && !reset) begin
            r_mem[{r_wbank, w_waddr}] <= {di_re, di_im};
        end
        if (w_issue) begin
            r_rd_data <= r_mem[{r_rbank, w_raddr}];
        end
    end

    // Reader next-state: issue one natural-order address per cycle while
    // draining, and chain into the other bank without a gap when it is full
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rbank_nxt = r_rbank;
        w_issue     = 1'b0;
        w_raddr     = r_rcnt;
        w_rd_done   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_issue     = 1'b1;
                    w_raddr     = '0;
                    w_rcnt_nxt  = c_ONE;
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_issue    = 1'b1;
                w_raddr    = r_rcnt;
                w_rcnt_nxt = r_rcnt + c_ONE;
                if (r_rcnt == c_LAST) begin
                    w_rd_done   = 1'b1;
                    w_rbank_nxt = ~r_rbank;
                    w_rcnt_nxt  = '0;
                    if (!r_full[~r_rbank]) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Reader state register and registered output-valid flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
            r_do_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_rbank <= w_rbank_nxt;
            r_do_en <= w_issue;
        end
    end

    // Data is masked to zero whenever the output is not valid
    assign do_en = r_do_en;
    assign do_re = r_do_en ? r_rd_data[2*WIDTH-1:WIDTH] : '0;
    assign do_im = r_do_en ? r_rd_data[WIDTH-1:0]       : '0;

endmodule
`default_nettype wire
